sar_cds_sequencer: RTL and testbench

//   Initiator side of the SAR ADC conversion handshake. Walks a ROWS x COLS pixel array and performs two
//   SAR conversions per pixel (reset level, then signal level) to implement correlated double sampling (CDS).

---
 rtl/sar_pkg.sv | 32 +++
 rtl/sar_pix_fifo.sv | 51 +++++
 rtl/sar_cds_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_sar_cds_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
// Shared types for the SAR correlated-double-sampling sequencer: FSM states,
// the FIFO entry layout and the clamped CDS subtraction.
package sar_pkg;

    localparam int PIX_RES = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONV_START,
        CONV_WAIT,
        EMIT,
        ADVANCE,
        FRAME_END
    } seq_state_t;

    typedef struct packed {
        logic [PIX_RES-1:0] data;
        logic               last;
        logic               err;
    } pix_entry_t;

    // Reset level minus signal level; a borrow means the signal exceeded the
    // reset level, which is clamped to zero rather than wrapping.
    function automatic logic [PIX_RES-1:0] cds_clamp(input logic [PIX_RES-1:0] rst_val,
                                                     input logic [PIX_RES-1:0] sig_val);
        logic [PIX_RES:0] diff;
        diff = {1'b0, rst_val} - {1'b0, sig_val};
        return diff[PIX_RES] ? '0 : diff[PIX_RES-1:0];
    endfunction

endpackage

// File: rtl/sar_pix_fifo.sv
// Small synchronous show-ahead FIFO for finished pixels; the head entry is
// visible on head_o whenever valid_o is high.
module sar_pix_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_ready_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty        = (wr_ptr_q == rd_ptr_q);
    assign full         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop       = pop_i && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign push_ready_o = !full || do_pop;
    assign do_push      = push_i && push_ready_o;
    assign valid_o      = !empty;
    assign head_o       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/sar_cds_sequencer.sv
// Walks the pixel array, runs a reset-level and a signal-level SAR conversion
// per pixel, and streams the clamped difference out through a small FIFO.
module sar_cds_sequencer
    import sar_pkg::*;
#(
    parameter int RES        = PIX_RES,
    parameter int COLS       = 4,
    parameter int ROWS       = 4,
    parameter int SETTLE     = 2,
    parameter int TIMEOUT    = 32,
    parameter int FIFO_DEPTH = 4,
    localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic [RW-1:0]  row_addr,
    output logic [CW-1:0]  col_addr,
    output logic           cds_phase,
    output logic           adc_enable,
    input  logic           adc_done,
    input  logic [RES-1:0] adc_value,
    output logic [RES-1:0] pix_data,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic           pix_last,
    output logic           pix_err,
    output logic           frame_done,
    output logic           timeout_err
);

    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [RW-1:0]  ROW_LAST    = RW'(ROWS - 1);
    localparam logic [CW-1:0]  COL_LAST    = CW'(COLS - 1);
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE - 1);
    localparam logic [WCW-1:0] WAIT_LAST   = WCW'(TIMEOUT - 1);

    seq_state_t     state_q, state_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic           phase_q, phase_d;
    logic [SCW-1:0] settle_q, settle_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic [RES-1:0] rst_q, rst_d;
    logic [RES-1:0] sig_q, sig_d;
    logic           err_q, err_d;
    logic           timeout_q, timeout_d;

    logic           capture;
    logic [RES-1:0] capture_val;
    logic           is_last;
    logic           fifo_push;
    logic           fifo_push_ready;
    pix_entry_t     push_entry;
    pix_entry_t     head_entry;

    assign is_last = (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        push_entry      = '0;
        push_entry.data = cds_clamp(rst_q, sig_q);
        push_entry.last = is_last;
        push_entry.err  = err_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            phase_q   <= 1'b0;
            settle_q  <= '0;
            wait_q    <= '0;
            rst_q     <= '0;
            sig_q     <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            phase_q   <= phase_d;
            settle_q  <= settle_d;
            wait_q    <= wait_d;
            rst_q     <= rst_d;
            sig_q     <= sig_d;
            err_q     <= err_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        phase_d     = phase_q;
        settle_d    = settle_q;
        wait_d      = wait_q;
        rst_d       = rst_q;
        sig_d       = sig_q;
        err_d       = err_q;
        timeout_d   = timeout_q;
        capture     = 1'b0;
        capture_val = '0;
        adc_enable  = 1'b0;
        fifo_push   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    timeout_d = 1'b0;
                    row_d     = '0;
                    col_d     = '0;
                    phase_d   = 1'b0;
                    settle_d  = '0;
                    err_d     = 1'b0;
                    state_d   = sar_pkg::SETTLE;
                end
            end
            sar_pkg::SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = CONV_START;
                else                         settle_d = settle_q + 1'b1;
            end
            CONV_START: begin
                adc_enable = 1'b1;
                wait_d     = '0;
                state_d    = CONV_WAIT;
            end
            CONV_WAIT: begin
                wait_d = wait_q + 1'b1;
                // The first wait cycle may still show the previous conversion's done level.
                if ((wait_q != '0) && adc_done) begin
                    capture     = 1'b1;
                    capture_val = adc_value;
                end else if (wait_q == WAIT_LAST) begin
                    capture   = 1'b1;
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end
                if (capture) begin
                    if (!phase_q) begin
                        rst_d    = capture_val;
                        phase_d  = 1'b1;
                        settle_d = '0;
                        state_d  = sar_pkg::SETTLE;
                    end else begin
                        sig_d   = capture_val;
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (fifo_push_ready) begin
                    fifo_push = 1'b1;
                    state_d   = ADVANCE;
                end
            end
            ADVANCE: begin
                phase_d  = 1'b0;
                err_d    = 1'b0;
                settle_d = '0;
                if (is_last) begin
                    state_d = FRAME_END;
                end else begin
                    state_d = sar_pkg::SETTLE;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            FRAME_END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy        = (state_q != IDLE) && (state_q != FRAME_END);
    assign frame_done  = (state_q == FRAME_END);
    assign timeout_err = timeout_q;
    assign row_addr    = row_q;
    assign col_addr    = col_q;
    assign cds_phase   = phase_q;

    sar_pix_fifo #(
        .WIDTH($bits(pix_entry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .push_ready_o(fifo_push_ready),
        .pop_i       (pix_ready),
        .head_o      (head_entry),
        .valid_o     (pix_valid)
    );

    assign pix_data = head_entry.data;
    assign pix_last = head_entry.last;
    assign pix_err  = head_entry.err;

endmodule

// File: tb/tb_sar_cds_sequencer.sv
// Bench for sar_cds_sequencer on a 2x4 array with a behavioural SAR model and
// a scoreboard of expected pixels filled whenever a frame is started.
module tb_sar_cds_sequencer;

    localparam int RES        = 8;
    localparam int COLS       = 4;
    localparam int ROWS       = 2;
    localparam int SETTLE     = 2;
    localparam int TIMEOUT    = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int NPIX       = ROWS * COLS;
    localparam int LAT        = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           busy;
    logic [0:0]     row_addr;
    logic [1:0]     col_addr;
    logic           cds_phase;
    logic           adc_enable;
    logic           adc_done;
    logic [RES-1:0] adc_value;
    logic [RES-1:0] pix_data;
    logic           pix_valid;
    logic           pix_ready;
    logic           pix_last;
    logic           pix_err;
    logic           frame_done;
    logic           timeout_err;

    typedef struct {
        int data;
        bit last;
        bit err;
    } exp_t;

    exp_t sb[$];
    exp_t expItem;

    int compareCnt   = 0;
    int mismatchCnt  = 0;
    int frameDoneCnt = 0;
    int enableCnt    = 0;
    int framesExp    = 0;

    int rstTab[NPIX];
    int sigTab[NPIX];
    int noDonePix   = -1;
    bit staleMode   = 1'b0;
    bit readyRandom = 1'b0;
    bit readyLevel  = 1'b1;

    int             busyCnt;
    logic [RES-1:0] pendVal;
    bit             pendNoDone;
    bit             staleClr;

    always #5 clk = ~clk;

    sar_cds_sequencer #(
        .RES       (RES),
        .COLS      (COLS),
        .ROWS      (ROWS),
        .SETTLE    (SETTLE),
        .TIMEOUT   (TIMEOUT),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .row_addr   (row_addr),
        .col_addr   (col_addr),
        .cds_phase  (cds_phase),
        .adc_enable (adc_enable),
        .adc_done   (adc_done),
        .adc_value  (adc_value),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .pix_err    (pix_err),
        .frame_done (frame_done),
        .timeout_err(timeout_err)
    );

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compareCnt++;
        if (actual != expected) begin
            mismatchCnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int pixIdx(input logic [0:0] r, input logic [1:0] c);
        return int'(r) * COLS + int'(c);
    endfunction

    // SAR model: done clears on the enable edge (or one edge late in stale mode),
    // then rises LAT edges later with the level of the addressed pixel/phase.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            adc_done   <= 1'b0;
            adc_value  <= '0;
            busyCnt    <= 0;
            pendVal    <= '0;
            pendNoDone <= 1'b0;
            staleClr   <= 1'b0;
        end else if (adc_enable) begin
            if (!staleMode) adc_done <= 1'b0;
            staleClr   <= staleMode;
            busyCnt    <= LAT;
            pendVal    <= cds_phase ? RES'(sigTab[pixIdx(row_addr, col_addr)])
                                    : RES'(rstTab[pixIdx(row_addr, col_addr)]);
            pendNoDone <= cds_phase && (pixIdx(row_addr, col_addr) == noDonePix);
        end else begin
            if (staleClr) begin
                adc_done <= 1'b0;
                staleClr <= 1'b0;
            end
            if (busyCnt != 0) begin
                busyCnt <= busyCnt - 1;
                if (busyCnt == 1 && !pendNoDone) begin
                    adc_done  <= 1'b1;
                    adc_value <= pendVal;
                end
            end
        end
    end

    // Output monitor: every accepted pixel is compared with the scoreboard head.
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) frameDoneCnt++;
            if (adc_enable) enableCnt++;
            if (pix_valid && pix_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_pixel", int'(pix_data), -1);
                end else begin
                    expItem = sb.pop_front();
                    checkOutput("pix_data", int'(pix_data), expItem.data);
                    checkOutput("pix_last", int'(pix_last), int'(expItem.last));
                    checkOutput("pix_err", int'(pix_err), int'(expItem.err));
                end
            end
        end
    end

    initial begin
        pix_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = readyRandom ? 1'($urandom_range(0, 1)) : readyLevel;
        end
    end

    task automatic pulseStart();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic applyStimulus();
        for (int p = 0; p < NPIX; p++) begin
            exp_t e;
            int   s;
            s      = (p == noDonePix) ? 0 : sigTab[p];
            e.data = (rstTab[p] >= s) ? rstTab[p] - s : 0;
            e.last = (p == NPIX - 1);
            e.err  = (p == noDonePix);
            sb.push_back(e);
        end
        framesExp++;
        pulseStart();
    endtask

    task automatic waitFrame();
        int n = 0;
        while (frameDoneCnt < framesExp && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_done_count", frameDoneCnt, framesExp);
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((sb.size() != 0 || pix_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checkOutput("queue_left", sb.size(), 0);
        checkOutput("valid_after_drain", int'(pix_valid), 0);
        checkOutput("frames_after_drain", frameDoneCnt, framesExp);
    endtask

    task automatic checkIdleOutputs(input string pfx);
        checkOutput({pfx, "_busy"}, int'(busy), 0);
        checkOutput({pfx, "_adc_enable"}, int'(adc_enable), 0);
        checkOutput({pfx, "_pix_valid"}, int'(pix_valid), 0);
        checkOutput({pfx, "_frame_done"}, int'(frame_done), 0);
        checkOutput({pfx, "_timeout_err"}, int'(timeout_err), 0);
        checkOutput({pfx, "_pix_data"}, int'(pix_data), 0);
        checkOutput({pfx, "_pix_last"}, int'(pix_last), 0);
        checkOutput({pfx, "_pix_err"}, int'(pix_err), 0);
        checkOutput({pfx, "_row_addr"}, int'(row_addr), 0);
        checkOutput({pfx, "_col_addr"}, int'(col_addr), 0);
        checkOutput({pfx, "_cds_phase"}, int'(cds_phase), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int e0;
        int n;
        int f0;

        start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkIdleOutputs("reset");
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] frame with rst=200 sig=50, extra start while busy");
        for (int p = 0; p < NPIX; p++) begin
            rstTab[p] = 200;
            sigTab[p] = 50;
        end
        applyStimulus();
        repeat (30) @(posedge clk);
        #1 checkOutput("busy_mid_frame", int'(busy), 1);
        pulseStart();
        waitFrame();
        waitDrain();
        repeat (5) @(negedge clk);
        checkOutput("busy_after_frame", int'(busy), 0);
        checkOutput("no_requeued_frame", frameDoneCnt, framesExp);
        checkOutput("timeout_err_clean", int'(timeout_err), 0);

        $display("[TB] clamp: sig above rst");
        for (int p = 0; p < NPIX; p++) begin
            rstTab[p] = 80;
            sigTab[p] = 90;
        end
        applyStimulus();
        waitFrame();
        waitDrain();

        $display("[TB] random levels with random consumer back-pressure");
        for (int p = 0; p < NPIX; p++) begin
            rstTab[p] = int'($urandom_range(0, 255));
            sigTab[p] = (p == 2) ? rstTab[p] : int'($urandom_range(0, 255));
        end
        readyRandom = 1'b1;
        applyStimulus();
        waitFrame();
        readyRandom = 1'b0;
        waitDrain();

        $display("[TB] signal phase of pixel (1,0) never completes");
        for (int p = 0; p < NPIX; p++) begin
            rstTab[p] = 120 + p;
            sigTab[p] = 20 + p;
        end
        noDonePix = 4;
        applyStimulus();
        waitFrame();
        waitDrain();
        noDonePix = -1;
        checkOutput("timeout_err_sticky", int'(timeout_err), 1);

        $display("[TB] consumer stalled: FIFO fills and sequencer holds in EMIT");
        for (int p = 0; p < NPIX; p++) begin
            rstTab[p] = 100 + 10 * p;
            sigTab[p] = 5 * p;
        end
        readyLevel = 1'b0;
        e0 = enableCnt;
        applyStimulus();
        repeat (3) @(negedge clk);
        checkOutput("timeout_err_cleared", int'(timeout_err), 0);
        repeat (300) @(negedge clk);
        checkOutput("enables_before_stall", enableCnt - e0, 10);
        checkOutput("nothing_popped", sb.size(), NPIX);
        checkOutput("valid_while_stalled", int'(pix_valid), 1);
        e0 = enableCnt;
        repeat (100) @(negedge clk);
        checkOutput("no_enable_while_stalled", enableCnt - e0, 0);
        checkOutput("busy_while_stalled", int'(busy), 1);
        readyLevel = 1'b1;
        waitFrame();
        waitDrain();

        $display("[TB] stale done level held into the blanking cycle");
        for (int p = 0; p < NPIX; p++) begin
            rstTab[p] = 200 - 5 * p;
            sigTab[p] = 10 + 7 * p;
        end
        staleMode = 1'b1;
        applyStimulus();
        waitFrame();
        waitDrain();
        staleMode = 1'b0;

        $display("[TB] reset during a conversion wait");
        for (int p = 0; p < NPIX; p++) begin
            rstTab[p] = 60 + 20 * p;
            sigTab[p] = 30;
        end
        readyLevel = 1'b0;
        e0 = enableCnt;
        applyStimulus();
        n = 0;
        while (enableCnt < e0 + 7 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("enable_before_reset", enableCnt - e0, 7);
        checkOutput("fifo_filled_before_reset", int'(pix_valid), 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #2;
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_pix_valid", int'(pix_valid), 0);
        checkOutput("abort_adc_enable", int'(adc_enable), 0);
        checkOutput("abort_pix_data", int'(pix_data), 0);
        checkOutput("abort_row_addr", int'(row_addr), 0);
        sb.delete();
        framesExp--;
        f0 = frameDoneCnt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        readyLevel = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("no_frame_done_after_abort", frameDoneCnt, f0);
        checkOutput("idle_after_abort", int'(busy), 0);
        applyStimulus();
        waitFrame();
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, mismatchCnt);
        $finish;
    end

endmodule
